// File: rtl/apd04_topk_pkg.sv
// Shared types and default sizing for the top-K result buffer.
package apd04_topk_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_TOP_K      = 128;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/apd04_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered (1-cycle) read.
module apd04_sdp_ram
  import apd04_topk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_TOP_K
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/apd04_topk_result_buffer.sv
// Captures a heap drain into RAM, then replays it on an AXI-Stream master.
// Define APD04_TOPK_DESCEND_EN for LIFO (reverse-arrival) output order; FIFO otherwise.
module apd04_topk_result_buffer
  import apd04_topk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TOP_K      = DEFAULT_TOP_K
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic [DATA_WIDTH-1:0]      s_axis_din_tdata,
  input  logic                       s_axis_din_tvalid,
  input  logic                       s_axis_din_tlast,
  output logic [DATA_WIDTH-1:0]      m_axis_dout_tdata,
  output logic                       m_axis_dout_tvalid,
  output logic                       m_axis_dout_tlast,
  input  logic                       m_axis_dout_tready,
  output logic [$clog2(TOP_K+1)-1:0] result_count,
  output logic                       busy,
  output logic                       overflow_err
);

  localparam int unsigned AW = $clog2(TOP_K);
  localparam int unsigned CW = $clog2(TOP_K + 1);

  typedef logic [DATA_WIDTH-1:0] payload_t;

  state_e   state, state_next;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [AW-1:0] rd_addr;
  logic          wr_en, rd_en, pop, drain_done;
  logic [1:0]    occ;
  logic          rd_pend, rd_pend_last;
  payload_t      ram_rdata, skid_data;
  logic          skid_valid, skid_last;

  apd04_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TOP_K)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_din_tdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= FILL;
    else          state <= state_next;
  end

  // Next state, RAM strobes; a read is only issued when its data is sure to find a free slot.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    drain_done = 1'b0;
    pop        = m_axis_dout_tvalid & m_axis_dout_tready;
    occ        = 2'(m_axis_dout_tvalid) + 2'(skid_valid) + 2'(rd_pend) - 2'(pop);
`ifdef APD04_TOPK_DESCEND_EN
    rd_addr    = AW'(result_count - CW'(1) - rd_ptr);
`else
    rd_addr    = AW'(rd_ptr);
`endif
    case (state)
      FILL: begin
        if (s_axis_din_tvalid) begin
          wr_en = 1'b1;
          if (s_axis_din_tlast || (result_count == CW'(TOP_K - 1))) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((rd_ptr < result_count) && (occ < 2'd2)) rd_en = 1'b1;
        if (pop && m_axis_dout_tlast) begin
          drain_done = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      result_count       <= '0;
      rd_pend            <= 1'b0;
      rd_pend_last       <= 1'b0;
      skid_valid         <= 1'b0;
      skid_last          <= 1'b0;
      skid_data          <= '0;
      m_axis_dout_tdata  <= '0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tlast  <= 1'b0;
      busy               <= 1'b0;
      overflow_err       <= 1'b0;
    end else begin
      busy         <= (state_next == DRAIN);
      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_ptr == result_count - CW'(1));
      if (state == DRAIN && s_axis_din_tvalid) overflow_err <= 1'b1;
      if (wr_en) begin
        wr_ptr       <= wr_ptr + AW'(1);
        result_count <= result_count + CW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + CW'(1);

      // Output register backed by a one-entry skid buffer absorbs the RAM read latency.
      if (!m_axis_dout_tvalid || pop) begin
        if (skid_valid) begin
          m_axis_dout_tvalid <= 1'b1;
          m_axis_dout_tdata  <= skid_data;
          m_axis_dout_tlast  <= skid_last;
          skid_valid         <= rd_pend;
          skid_data          <= ram_rdata;
          skid_last          <= rd_pend_last;
        end else begin
          m_axis_dout_tvalid <= rd_pend;
          m_axis_dout_tlast  <= rd_pend && rd_pend_last;
          if (rd_pend) m_axis_dout_tdata <= ram_rdata;
        end
      end else if (rd_pend) begin
        skid_valid <= 1'b1;
        skid_data  <= ram_rdata;
        skid_last  <= rd_pend_last;
      end

      if (drain_done) begin
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        result_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apd04_topk_result_buffer.sv
// Scoreboard bench for apd04_topk_result_buffer (TOP_K=4, DATA_WIDTH=16), both output orders.
module tb_apd04_topk_result_buffer;

  localparam int unsigned DW = 16;
  localparam int unsigned K  = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [DW-1:0] din_tdata;
  logic          din_tvalid, din_tlast;
  logic [DW-1:0] dout_tdata;
  logic          dout_tvalid, dout_tlast, dout_tready;
  logic [2:0]    result_count;
  logic          busy, overflow_err;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  apd04_topk_result_buffer #(.DATA_WIDTH(DW), .TOP_K(K)) dut (
    .clk                (clk),
    .aresetn            (aresetn),
    .s_axis_din_tdata   (din_tdata),
    .s_axis_din_tvalid  (din_tvalid),
    .s_axis_din_tlast   (din_tlast),
    .m_axis_dout_tdata  (dout_tdata),
    .m_axis_dout_tvalid (dout_tvalid),
    .m_axis_dout_tlast  (dout_tlast),
    .m_axis_dout_tready (dout_tready),
    .result_count       (result_count),
    .busy               (busy),
    .overflow_err       (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(dout_tvalid), 32'd1);
        check("stall_data", 32'(dout_tdata), 32'(prev_data));
        check("stall_last", 32'(dout_tlast), 32'(prev_last));
      end
      if (dout_tvalid && dout_tready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0d with nothing expected at %0t", dout_tdata, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", 32'(dout_tdata), 32'(e.data));
          check("out_last", 32'(dout_tlast), 32'(e.last));
        end
        hs_cnt++;
      end
      stall_prev = dout_tvalid && !dout_tready;
      prev_data  = dout_tdata;
      prev_last  = dout_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic l);
    din_tvalid = 1'b1;
    din_tdata  = d;
    din_tlast  = l;
    tick();
    din_tvalid = 1'b0;
    din_tlast  = 1'b0;
  endtask

  // Expected replay order of a captured set of n values.
  task automatic expect_set(input logic [DW-1:0] v [4], input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
`ifdef APD04_TOPK_DESCEND_EN
      e.data = v[n-1-i];
`else
      e.data = v[i];
`endif
      e.last = (i == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle(input string name, input bit toggle);
    for (int i = 0; i < 60 && busy; i++) begin
      tick();
      if (toggle) dout_tready = ~dout_tready;
    end
    check(name, 32'(busy), 32'd0);
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({name, "_count_clr"}, 32'(result_count), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tvalid"}, 32'(dout_tvalid), 32'd0);
    check({name, "_tlast"}, 32'(dout_tlast), 32'd0);
    check({name, "_tdata"}, 32'(dout_tdata), 32'd0);
    check({name, "_count"}, 32'(result_count), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_ovf"}, 32'(overflow_err), 32'd0);
  endtask

  initial begin
    int base;
    aresetn     = 1'b0;
    din_tdata   = '0;
    din_tvalid  = 1'b0;
    din_tlast   = 1'b0;
    dout_tready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    aresetn = 1'b1;
    tick();

    // Four-beat set, ready held high: no bubbles, four handshakes within six cycles.
    dout_tready = 1'b1;
    expect_set('{16'd3, 16'd5, 16'd7, 16'd9}, 4);
    base = hs_cnt;
    beat(16'd3, 1'b0);
    beat(16'd5, 1'b0);
    beat(16'd7, 1'b0);
    beat(16'd9, 1'b1);
    check("t1_count", 32'(result_count), 32'd4);
    check("t1_busy", 32'(busy), 32'd1);
    repeat (6) tick();
    check("t1_burst_beats", 32'(hs_cnt - base), 32'd4);
    wait_idle("t1_idle", 1'b0);

    // Single-beat set held under backpressure for five cycles.
    dout_tready = 1'b0;
    expect_set('{16'd42, 16'd0, 16'd0, 16'd0}, 1);
    base = hs_cnt;
    beat(16'd42, 1'b1);
    check("t2_count", 32'(result_count), 32'd1);
    repeat (5) tick();
    check("t2_held_valid", 32'(dout_tvalid), 32'd1);
    check("t2_held_last", 32'(dout_tlast), 32'd1);
    dout_tready = 1'b1;
    wait_idle("t2_idle", 1'b0);
    check("t2_beats", 32'(hs_cnt - base), 32'd1);

    // Capacity reached without tlast; a beat arriving in DRAIN is dropped.
    dout_tready = 1'b0;
    expect_set('{16'd1, 16'd2, 16'd3, 16'd4}, 4);
    base = hs_cnt;
    beat(16'd1, 1'b0);
    beat(16'd2, 1'b0);
    beat(16'd3, 1'b0);
    beat(16'd4, 1'b0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_ovf_before", 32'(overflow_err), 32'd0);
    beat(16'd8, 1'b0);
    check("t3_ovf", 32'(overflow_err), 32'd1);
    check("t3_count", 32'(result_count), 32'd4);
    repeat (3) tick();
    dout_tready = 1'b1;
    wait_idle("t3_idle", 1'b0);
    check("t3_beats", 32'(hs_cnt - base), 32'd4);
    check("t3_ovf_sticky", 32'(overflow_err), 32'd1);

    // Ready toggling every cycle during a four-beat drain.
    dout_tready = 1'b1;
    expect_set('{16'd11, 16'd22, 16'd33, 16'd44}, 4);
    base = hs_cnt;
    beat(16'd11, 1'b0);
    beat(16'd22, 1'b0);
    beat(16'd33, 1'b0);
    beat(16'd44, 1'b1);
    wait_idle("t4_idle", 1'b1);
    check("t4_beats", 32'(hs_cnt - base), 32'd4);

    // Reset after the second output handshake, then a fresh two-beat set.
    dout_tready = 1'b1;
    expect_set('{16'd100, 16'd101, 16'd102, 16'd103}, 4);
    base = hs_cnt;
    beat(16'd100, 1'b0);
    beat(16'd101, 1'b0);
    beat(16'd102, 1'b0);
    beat(16'd103, 1'b1);
    for (int i = 0; i < 40 && hs_cnt < base + 2; i++) tick();
    check("t5_two_beats", 32'(hs_cnt - base), 32'd2);
    aresetn = 1'b0;
    sb.delete();
    #1;
    check_all_zero("t5_midreset");
    tick();
    aresetn = 1'b1;
    tick();
    check_all_zero("t5_after");
    expect_set('{16'd10, 16'd20, 16'd0, 16'd0}, 2);
    base = hs_cnt;
    beat(16'd10, 1'b0);
    beat(16'd20, 1'b1);
    check("t5_count", 32'(result_count), 32'd2);
    wait_idle("t5_idle", 1'b0);
    check("t5_beats", 32'(hs_cnt - base), 32'd2);

    repeat (3) tick();
    check("final_no_valid", 32'(dout_tvalid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apd04_topk_result_buffer.md
APD04_TOPK_RESULT_BUFFER -- requirements
Module: apd04_topk_result_buffer

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 16, payload width; TOP_K, default 128, result capacity (power of 2, >=2).
REQ-002 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 aresetn  input  1  asynchronous, active-low reset.
REQ-004 s_axis_din_tdata  input  DATA_WIDTH  heap result beat.
REQ-005 s_axis_din_tvalid  input  1  result beat valid; no tready exists, so every valid beat is presented exactly once.
REQ-006 s_axis_din_tlast  input  1  final result of the heap drain.
REQ-007 m_axis_dout_tdata  output  DATA_WIDTH  reordered result beat.
REQ-008 m_axis_dout_tvalid  output  1  output beat valid.
REQ-009 m_axis_dout_tlast  output  1  last beat of the result set.
REQ-010 m_axis_dout_tready  input  1  downstream ready.
REQ-011 result_count  output  $clog2(TOP_K+1)  number of beats captured in the current set.
REQ-012 busy  output  1  high while in the DRAIN state.
REQ-013 overflow_err  output  1  sticky flag: an input beat was dropped.

Function
REQ-014 The FSM SHALL have two states. FILL is entered from reset. DRAIN is entered from FILL.
REQ-015 In FILL, each s_axis_din_tvalid beat SHALL be written to the buffer at wr_ptr, wr_ptr SHALL increment, and result_count SHALL increment.
REQ-016 FILL SHALL go to DRAIN on the cycle after a beat with tlast=1 is accepted, or after the TOP_K-th beat is accepted, whichever comes first.
REQ-017 An input beat arriving while in DRAIN SHALL be dropped, SHALL set overflow_err, and SHALL not alter buffer contents or result_count.
REQ-018 m_axis_dout_tvalid SHALL assert no later than 2 cycles after DRAIN is entered. It SHALL then stay high until the last beat handshakes.
REQ-019 With m_axis_dout_tready held high, output SHALL sustain one beat per cycle with no bubbles.
REQ-020 tdata and tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-021 m_axis_dout_tlast SHALL be high only on beat number result_count of the output set.
REQ-022 On the handshake of the tlast beat, the block SHALL return to FILL on the next cycle and SHALL clear result_count, wr_ptr and rd_ptr. overflow_err SHALL persist.
REQ-023 A set of 1 beat (tlast on the first beat) SHALL produce exactly one output beat with tlast=1.
REQ-024 Pointer arithmetic SHALL NOT wrap within a set: reads SHALL cover only indices 0..result_count-1.

Reset
REQ-025 While aresetn=0, regardless of state: m_axis_dout_tvalid=0, m_axis_dout_tlast=0, m_axis_dout_tdata=0, result_count=0, busy=0, overflow_err=0.
REQ-026 On reset, all pointers SHALL clear and the state SHALL be FILL.
REQ-027 A reset asserted mid-fill or mid-drain SHALL discard the set. Buffer RAM contents need not be cleared.

Configuration
REQ-028 When APD04_TOPK_DESCEND_EN is defined, output order SHALL be LIFO (reverse of arrival). Ascending heap pops SHALL therefore emerge as descending top-K.
REQ-029 When APD04_TOPK_DESCEND_EN is not defined, output order SHALL be FIFO (arrival order). All other behaviour SHALL be identical.

Structure
REQ-030 Package apd04_topk_pkg SHALL hold the FSM state enum (FILL, DRAIN) and the default DATA_WIDTH/TOP_K constants. The payload typedef SHALL be declared in the module, parameterized by DATA_WIDTH.
REQ-031 Storage SHALL be one sub-module, apd04_sdp_ram: simple dual-port, TOP_K x DATA_WIDTH, 1-cycle synchronous read. The output skid/prefetch logic SHALL live in the top module.

Verification (TOP_K=4, DATA_WIDTH=16)
REQ-032 Input 3,5,7,9 with tlast on 9, tready=1, DESCEND_EN defined -> output 9,7,5,3 on consecutive cycles, tlast on 3, result_count=4.
REQ-033 Same stimulus without DESCEND_EN -> output 3,5,7,9, tlast on 9.
REQ-034 Input 42 with tlast, tready low for 5 cycles then high -> tvalid held with data 42 and tlast=1 stable; one handshake, then busy=0.
REQ-035 Input 1,2,3,4 (no tlast), then 8 during DRAIN -> DRAIN entered after beat 4, 8 dropped, overflow_err=1, 4 beats output.
REQ-036 Toggle tready 1,0,1,0 during a 4-beat drain -> no beat lost or duplicated, and data is stable across stalls.
REQ-037 aresetn low for 1 cycle after the 2nd output handshake -> all outputs 0. A following 2-beat set 10,20 (tlast on 20) -> 20,10 with DESCEND_EN.
